// File: rtl/array_mult_pipe_pkg.sv
// Shared fixed-point definitions for the transform blocks: word format and
// the multiplier pipeline depth.
package array_mult_pipe_pkg;

  localparam int unsigned FX_WIDTH = 27;
  localparam int unsigned FX_FRAC  = 8;
  localparam int unsigned LATENCY  = 4;
  localparam int unsigned FX_LANES = 6;

  typedef logic signed [FX_WIDTH-1:0] fx_word_t;

endpackage

// File: rtl/fx_mult_lane.sv
// One fixed-point multiplier lane: operand, raw product, shift/saturate and
// output stages, all advancing together on en.
module fx_mult_lane
  import array_mult_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = FX_WIDTH,
  parameter int unsigned FRAC  = FX_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] result,
  output logic                    sat,
  output logic                    sat_s3
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic signed [PW-1:0]    prod_q;
  logic signed [WIDTH-1:0] val_q;
  logic signed [PW-1:0]    shifted_c;
  logic        [WIDTH:0]   hi_c;
  logic signed [WIDTH-1:0] sat_val_c;
  logic                    sat_c;

  // Floor shift, then clamp when the bits above the word are not a pure sign extension
  always_comb begin
    shifted_c = prod_q >>> FRAC;
    hi_c      = shifted_c[PW-1:WIDTH-1];
    sat_val_c = shifted_c[WIDTH-1:0];
    sat_c     = 1'b0;
    if (!((hi_c == '0) || (hi_c == '1))) begin
      sat_c     = 1'b1;
      sat_val_c = shifted_c[PW-1] ? MIN_V : MAX_V;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      val_q  <= '0;
      sat_s3 <= 1'b0;
      result <= '0;
      sat    <= 1'b0;
    end else if (en) begin
      a_q    <= a;
      b_q    <= b;
      prod_q <= PW'(a_q) * PW'(b_q);
      val_q  <= sat_val_c;
      sat_s3 <= sat_c;
      result <= val_q;
      sat    <= sat_s3;
    end
  end

endmodule

// File: rtl/array_mult_pipe.sv
// Multi-lane signed fixed-point multiplier with a shared valid chain and
// per-lane sticky saturation status.
module array_mult_pipe
  import array_mult_pipe_pkg::*;
#(
  parameter int unsigned LANES = FX_LANES,
  parameter int unsigned WIDTH = FX_WIDTH,
  parameter int unsigned FRAC  = FX_FRAC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic [LANES-1:0][WIDTH-1:0]  dataa,
  input  logic [LANES-1:0][WIDTH-1:0]  datab,
  input  logic                         clr_sat,
  output logic [LANES-1:0][WIDTH-1:0]  result,
  output logic                         out_valid,
  output logic [LANES-1:0]             sat,
  output logic [LANES-1:0]             sat_sticky
);

  logic [LATENCY-1:0] vld_q;
  logic [LANES-1:0]   sat_s3;
  logic [LANES-1:0]   set_c;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    fx_mult_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .a      (dataa[g]),
      .b      (datab[g]),
      .result (result[g]),
      .sat    (sat[g]),
      .sat_s3 (sat_s3[g])
    );
  end

  // Valid qualification travels beside the free-running datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[LATENCY-2:0], in_valid};
    end
  end

  assign out_valid = vld_q[LATENCY-1];

  // Sticky sets on the edge that loads a valid saturated sample into the output stage
  always_comb begin
    set_c = '0;
    if (en && vld_q[LATENCY-2]) begin
      set_c = sat_s3;
    end
  end

  // A coinciding set wins over clear; clear ignores en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_sticky <= '0;
    end else begin
      sat_sticky <= (sat_sticky & ~{LANES{clr_sat}}) | set_c;
    end
  end

endmodule

// File: doc/array_mult_pipe.md
ARRAY_MULT_PIPE -- requirements
Module: array_mult_pipe

Interface
REQ-001 Parameter LANES, default 6, is the number of independent multiplier lanes.
REQ-002 Parameter WIDTH, default 27, is the signed fixed-point word width.
REQ-003 Parameter FRAC, default 8, is the number of fractional bits (256 = 1.0).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  pipeline advance enable; 0 = whole pipeline holds.
REQ-007 in_valid  in  1  lane operands on dataa/datab are valid this cycle.
REQ-008 dataa  in  LANES x WIDTH  signed operand A per lane.
REQ-009 datab  in  LANES x WIDTH  signed operand B per lane.
REQ-010 clr_sat  in  1  synchronous clear of sat_sticky.
REQ-011 result  out  LANES x WIDTH  signed fixed-point product per lane.
REQ-012 out_valid  out  1  result/sat correspond to a valid input sample.
REQ-013 sat  out  LANES  per-lane saturation flag aligned with result.
REQ-014 sat_sticky  out  LANES  per-lane OR of all sat seen since last clear/reset.

Function
REQ-015 Each lane SHALL compute the full 2*WIDTH signed product dataa*datab, arithmetic-shift it right by FRAC (truncation toward minus infinity), then saturate to WIDTH bits signed.
REQ-016 Saturation SHALL clamp to +(2^(WIDTH-1)-1) or -(2^(WIDTH-1)) and assert that lane's sat in the same cycle as the clamped result.
REQ-017 Latency SHALL be exactly 4 enabled cycles: S1 register operands, S2 register raw product, S3 register shifted/saturated value, S4 register outputs.
REQ-018 in_valid SHALL travel through a 4-deep valid shift chain in lockstep with data; out_valid is its S4 value.
REQ-019 When en=0 every pipeline register (data, valid, sat) SHALL hold; outputs stay constant; inputs in that cycle are ignored.
REQ-020 Data registers SHALL load regardless of in_valid (free-running datapath); only the valid chain carries qualification.
REQ-021 sat_sticky[k] SHALL set on any cycle where out_valid=1, en=1 and sat[k]=1 at S4 load.
REQ-022 clr_sat=1 SHALL clear sat_sticky next edge; if a set event coincides, set wins.
REQ-023 clr_sat SHALL act independent of en.
REQ-024 Lanes SHALL be fully independent; no cross-lane arithmetic.

Reset
REQ-025 rst=0 SHALL asynchronously clear result, sat, sat_sticky, out_valid and all internal valid/data stages to 0.
REQ-026 Reset mid-operation SHALL discard all in-flight samples; first out_valid after release occurs 4 enabled cycles after the first in_valid accepted post-release.

Structure
REQ-027 WIDTH, FRAC, LATENCY (=4) and the fixed-point word typedef SHALL live in the shared fixed-point package used by the transform blocks.
REQ-028 One sub-module, fx_mult_lane (one lane: S1-S4 data/sat stages), SHALL be instantiated LANES times by a generate loop; valid chain and sat_sticky live in the top.

Verification
REQ-029 Lane0 A=256, B=256, in_valid=1 one cycle, en=1 -> result[0]=256, out_valid=1 exactly 4 cycles later, sat[0]=0.
REQ-030 A=-1, B=1 -> result=-1 (truncation toward -inf); A=-256, B=128 -> result=-128.
REQ-031 A=2^26-1, B=512 -> result=67108863, sat=1, sat_sticky=1; A=-2^26, B=512 -> result=-67108864, sat=1.
REQ-032 Back-to-back samples 1..6 with en=0 for 2 cycles mid-stream -> outputs in order, no loss/duplication, latency stretched by 2, outputs frozen while en=0.
REQ-033 Assert rst=0 with 3 samples in flight -> all outputs 0 immediately; no out_valid until 4 cycles after new input.
REQ-034 clr_sat pulsed in same cycle as new saturating output -> sat_sticky stays 1; clr_sat alone -> sat_sticky 0 next cycle.
